// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode
// Description : Instruction fetch/decode sequencer for the 8-bit datapath.
//               Fetches 16-bit words over a req/ack handshake and splits each
//               word into opcode, register and immediate fields. It issues one
//               instruction per issue_valid_o pulse and owns the PC and the
//               run/halt state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   FD_BRANCH_EN - opcode 4'hE becomes JMP. In DECODE it loads PC from IR[7:0]
//                  and does not issue. When the macro is undefined, 4'hE issues
//                  like any other opcode.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start_i               leave IDLE and begin fetching (sampled in IDLE only)
//   stall_i               hold the instruction in DECODE
//   imem_req_o/addr_o     fetch request and address (= PC)
//   imem_rdata_i/ack_i    fetched word and its completion strobe
//   Opcode_o .. Immediate_o  decoded fields of the issued instruction
//   issue_valid_o         one-cycle issue pulse
//   halted_o              HALT executed (sticky until reset)
//   pc_out_o              current PC
// ============================================================================
module fetch_decode #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                stall_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic [15:0]         imem_rdata_i,
  input  logic                imem_ack_i,
  output logic [3:0]          Opcode_o,
  output logic [2:0]          DestReg_o,
  output logic [2:0]          SrcReg1_o,
  output logic [2:0]          SrcReg2_o,
  output logic [7:0]          Immediate_o,
  output logic                issue_valid_o,
  output logic                halted_o,
  output logic [PC_WIDTH-1:0] pc_out_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_NOP  = 4'h0;
`ifdef FD_BRANCH_EN
  localparam logic [3:0] OP_JMP  = 4'hE;
`endif

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [3:0]            opcode_q, opcode_d;
  logic [2:0]            dest_q, dest_d;
  logic [2:0]            src1_q, src1_d;
  logic [2:0]            src2_q, src2_d;
  logic [7:0]            imm_q, imm_d;
  logic                  issue_q, issue_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      opcode_q <= OP_NOP;
      dest_q   <= 3'd0;
      src1_q   <= 3'd0;
      src2_q   <= 3'd0;
      imm_q    <= 8'h00;
      issue_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      imm_q    <= imm_d;
      issue_q  <= issue_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    // Opcode falls back to NOP on every non-issue cycle. The other fields keep
    // their previous values so they do not toggle needlessly.
    opcode_d = OP_NOP;
    dest_d   = dest_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    imm_d    = imm_q;
    issue_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!stall_i) begin
          if (ir_q[15:12] == OP_HALT) begin
            state_d = S_HALT;
          end
`ifdef FD_BRANCH_EN
          else if (ir_q[15:12] == OP_JMP) begin
            // The 8-bit target is resized to the PC width: zero-extended when
            // the PC is wider, truncated when it is narrower.
            pc_d    = PC_WIDTH'(ir_q[7:0]);
            state_d = S_FETCH;
          end
`endif
          else begin
            opcode_d = ir_q[15:12];
            dest_d   = ir_q[11:9];
            src1_d   = ir_q[8:6];
            src2_d   = ir_q[5:3];
            imm_d    = ir_q[7:0];
            issue_d  = 1'b1;
            pc_d     = pc_q + PC_WIDTH'(1);
            state_d  = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The request is decoded from the state register. An asynchronous reset
  // therefore withdraws it at once, even in the middle of a fetch.
  assign imem_req_o    = (state_q == S_FETCH);
  assign imem_addr_o   = pc_q;
  assign pc_out_o      = pc_q;
  assign halted_o      = (state_q == S_HALT);
  assign Opcode_o      = opcode_q;
  assign DestReg_o     = dest_q;
  assign SrcReg1_o     = src1_q;
  assign SrcReg2_o     = src2_q;
  assign Immediate_o   = imm_q;
  assign issue_valid_o = issue_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode
// Description : Self-checking bench for fetch_decode. A reference PC and a
//               per-instruction outcome are derived from the instruction
//               word rules. Random words, wait states and stalls are applied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode;

  localparam int         PW  = 8;
  localparam logic [7:0] RPC = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          stall_i;
  logic          imem_req_o;
  logic [PW-1:0] imem_addr_o;
  logic [15:0]   imem_rdata_i;
  logic          imem_ack_i;
  logic [3:0]    Opcode_o;
  logic [2:0]    DestReg_o;
  logic [2:0]    SrcReg1_o;
  logic [2:0]    SrcReg2_o;
  logic [7:0]    Immediate_o;
  logic          issue_valid_o;
  logic          halted_o;
  logic [PW-1:0] pc_out_o;

  fetch_decode #(.PC_WIDTH(PW), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .imem_ack_i   (imem_ack_i),
    .Opcode_o     (Opcode_o),
    .DestReg_o    (DestReg_o),
    .SrcReg1_o    (SrcReg1_o),
    .SrcReg2_o    (SrcReg2_o),
    .Immediate_o  (Immediate_o),
    .issue_valid_o(issue_valid_o),
    .halted_o     (halted_o),
    .pc_out_o     (pc_out_o)
  );

  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0; stall_i = 1'b0;
    imem_ack_i = 1'b0; imem_rdata_i = 16'h0000;
    @(negedge clk); @(negedge clk);
    chk("rst_req", imem_req_o, 0);
    chk("rst_issue", issue_valid_o, 0);
    chk("rst_opcode", Opcode_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_pc", pc_out_o, RPC);
    rst_n = 1'b1;
    m_pc  = RPC;
    // The design must stay idle while start is low.
    @(negedge clk); @(negedge clk);
    chk("idle_req", imem_req_o, 0);
  endtask

  task automatic kick();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_req", imem_req_o, 1);
  endtask

  // Fetch one word with wt wait states, then hold it in DECODE with st stall
  // cycles. The result is checked against the instruction-level rules.
  task automatic run_instr(input logic [15:0] w, input int wt, input int st);
    int cnt;
    cnt = 0;
    while (imem_req_o !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("fetch_req", imem_req_o, 1);
    chk("fetch_addr", imem_addr_o, m_pc);
    for (int i = 0; i < wt; i++) begin
      stall_i = 1'($urandom_range(0, 1));   // no effect while fetching
      start_i = 1'($urandom_range(0, 1));   // ignored outside IDLE
      @(negedge clk);
      chk("wait_req", imem_req_o, 1);
      chk("wait_addr", imem_addr_o, m_pc);
      chk("wait_noissue", issue_valid_o, 0);
    end
    start_i = 1'b0;
    imem_ack_i = 1'b1; imem_rdata_i = w; stall_i = (st > 0);
    @(negedge clk);
    imem_ack_i = 1'b0; imem_rdata_i = 16'($urandom);
    chk("dec_req", imem_req_o, 0);
    chk("dec_issue", issue_valid_o, 0);
    chk("dec_opcode", Opcode_o, 0);
    for (int i = 0; i < st; i++) begin
      // Acks seen in DECODE must not overwrite the held word.
      imem_ack_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_issue", issue_valid_o, 0);
      chk("stall_pc", pc_out_o, m_pc);
      chk("stall_req", imem_req_o, 0);
      if (i == st - 1) begin
        stall_i = 1'b0;
        imem_ack_i = 1'b0;
      end
    end
    @(negedge clk);
    if (w[15:12] == 4'hF) begin
      chk("halt_flag", halted_o, 1);
      chk("halt_issue", issue_valid_o, 0);
      chk("halt_req", imem_req_o, 0);
      chk("halt_pc", pc_out_o, m_pc);
    end
`ifdef FD_BRANCH_EN
    else if (w[15:12] == 4'hE) begin
      m_pc = w[7:0];
      chk("jmp_issue", issue_valid_o, 0);
      chk("jmp_req", imem_req_o, 1);
      chk("jmp_addr", imem_addr_o, m_pc);
    end
`endif
    else begin
      m_pc = m_pc + 8'd1;
      chk("iss_valid", issue_valid_o, 1);
      chk("iss_opcode", Opcode_o, w[15:12]);
      chk("iss_dest", DestReg_o, w[11:9]);
      chk("iss_src1", SrcReg1_o, w[8:6]);
      chk("iss_src2", SrcReg2_o, w[5:3]);
      chk("iss_imm", Immediate_o, w[7:0]);
      chk("iss_pc", pc_out_o, m_pc);
    end
  endtask

  initial begin
    do_reset();
    kick();
    // Zero-wait fetch. The first address is FF and the PC wraps to 00.
    run_instr(16'h1A5F, 0, 0);
    // Long ack wait. The address after the wrap must be 00.
    run_instr({4'h3, 12'($urandom)}, 4, 0);
    // Five stall cycles in DECODE.
    run_instr({4'h7, 12'($urandom)}, 0, 5);
    // Opcode E: jump or plain issue, depending on the build.
    run_instr(16'hE020, 1, 0);
    for (int k = 0; k < 30; k++) begin
      run_instr({4'($urandom_range(0, 14)), 12'($urandom)},
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // An asynchronous reset in the middle of a fetch withdraws the request at once.
    chk("midfetch_req_before", imem_req_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midfetch_req_after", imem_req_o, 0);
    chk("midfetch_pc", pc_out_o, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = RPC;

    // HALT is sticky, and start is ignored while halted.
    kick();
    run_instr(16'hF000, 0, 1);
    start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halted_hold", halted_o, 1);
      chk("halted_req", imem_req_o, 0);
      chk("halted_issue", issue_valid_o, 0);
    end
    start_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_flag", halted_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("halt_rst_idle", imem_req_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
